iod_dly_step_ctrl: RTL and testbench
====================================

Name: iod_dly_step_ctrl

Overview:
- Sequencer for the dynamic delay line of one PF_IOD lane (DDR3 address/command and DQ/DQS pads).
- Converts an absolute tap-target request into a timed series of DELAY_LINE_MOVE pulses, with DELAY_LINE_DIRECTION set up beforehand, or into a DELAY_LINE_LOAD preset.
- Tracks the current tap, honours DELAY_LINE_OUT_OF_RANGE and reports completion to the training/calibration FSM.
- Sits between the DDR PHY training logic and the IOD instance, in the FAB_CLK domain.

Parameters:
- TAP_W, 8, width of tap target/counter
- TAP_MAX, 255, highest legal tap; requests above it are clamped
- LOAD_VAL, 1, tap value the IOD assumes after DELAY_LINE_LOAD (matches TX/RX_DELAY_VAL preset)
- SETTLE_CYC, 4, idle FAB_CLK cycles after every MOVE/LOAD pulse (≥1)

Ports:
- FAB_CLK  in  1  fabric clock; all logic is rising-edge.
- ARST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request strobe.
- REQ_READY  out  1  request accepted when REQ_VALID&&REQ_READY.
- REQ_LOAD  in  1  1 = preset via LOAD; 0 = move to REQ_TARGET.
- REQ_TARGET  in  TAP_W  absolute target tap.
- RESP_VALID  out  1  one-cycle completion pulse.
- RESP_ERR  out  1  qualified by RESP_VALID; 1 = out-of-range abort.
- RESP_CLAMPED  out  1  qualified by RESP_VALID; target was clamped to TAP_MAX.
- CUR_TAP  out  TAP_W  tracked current tap.
- DELAY_LINE_MOVE  out  1  to IOD.
- DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment.
- DELAY_LINE_LOAD  out  1  to IOD.
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD.

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0 and CUR_TAP to LOAD_VAL.
  - The FSM enters INIT. The first cycle after release starts an automatic LOAD sequence.
  - Reset mid-sequence aborts immediately and no RESP_VALID is issued.
- States: INIT, IDLE, LOAD, SETUP, MOVE, GAP, DONE, ERR.
- INIT: go to LOAD, with no response at the end (internal flag).
- IDLE:
  - REQ_READY=1 only here.
  - On accept, REQ_LOAD=1 goes to LOAD.
  - Otherwise latch tgt=min(REQ_TARGET,TAP_MAX) and set the clamp flag if REQ_TARGET>TAP_MAX.
  - tgt==CUR_TAP goes to DONE (zero moves; RESP_VALID 2 cycles after accept). Otherwise go to SETUP.
- LOAD:
  - DELAY_LINE_LOAD=1 for exactly 1 cycle.
  - CUR_TAP<=LOAD_VAL, then SETTLE_CYC cycles of wait.
  - Then DONE, or IDLE if entered from INIT.
- SETUP:
  - DELAY_LINE_DIRECTION<=(tgt>CUR_TAP) for 1 cycle with MOVE=0.
  - DIRECTION holds that value until the sequence ends (stable ≥1 cycle before and during every MOVE).
- MOVE: DELAY_LINE_MOVE=1 for exactly 1 cycle; CUR_TAP ±1.
- GAP:
  - Count SETTLE_CYC cycles with MOVE=0.
  - DELAY_LINE_OUT_OF_RANGE is sampled every GAP cycle; if it is 1, go to ERR immediately.
  - At the end of the count, CUR_TAP==tgt goes to DONE, otherwise back to MOVE (no repeated SETUP).
- DONE: RESP_VALID=1, RESP_ERR=0, RESP_CLAMPED=flag for 1 cycle; then IDLE.
- ERR: RESP_VALID=1, RESP_ERR=1 for 1 cycle; CUR_TAP holds its last value; then IDLE.
- Move timing:
  - Move count |tgt−CUR_TAP|; MOVE pulses are spaced SETTLE_CYC+1 cycles apart.
  - Total latency from accept to RESP_VALID = 2 + N·(SETTLE_CYC+1) + 1.
- CUR_TAP never wraps: the clamp guarantees 0 ≤ CUR_TAP ≤ TAP_MAX.
- DELAY_LINE_OUT_OF_RANGE is ignored outside GAP.
- MOVE and LOAD are never asserted in the same cycle.
- REQ fields are sampled only on accept; later changes are ignored.

Optional Feature:
- Macro: IOD_DLY_STAT_EN.
- Defined:
  - Adds outputs STAT_MOVES[15:0] (total MOVE pulses, saturating at 0xFFFF) and STAT_OOR[7:0] (ERR count, saturating).
  - Both counters are cleared by ARST or by input STAT_CLR (synchronous, priority over increment).
- Undefined: no stat ports and no counters. All other behaviour is identical.

Decomposition:
- Package iod_dly_pkg holds:
  - the state enum type dly_state_t;
  - localparam DIR_INC=1'b1;
  - a function for settle-counter width, clog2(SETTLE_CYC+1).
- One sub-module, iod_dly_settle_cnt: a loadable down-counter with a zero flag, reused by LOAD and GAP.

Test Plan:
- Reset release → one LOAD pulse at cycle 1, no RESP_VALID, CUR_TAP=1, REQ_READY=1 at cycle 1+SETTLE_CYC+1.
- CUR_TAP=1, target 4 (SETTLE_CYC=4) → DIRECTION=1 from SETUP, 3 MOVE pulses 5 cycles apart, CUR_TAP=4, RESP_VALID at accept+18, RESP_ERR=0.
- CUR_TAP=4, target 4 → zero MOVEs, RESP_VALID at accept+2.
- TAP_MAX=200, target 250 from 198 → 2 MOVEs, CUR_TAP=200, RESP_CLAMPED=1.
- OUT_OF_RANGE forced high after the 2nd of 5 MOVEs → ERR, RESP_ERR=1, CUR_TAP=start+2, no further MOVE.
- ARST asserted during GAP → MOVE/LOAD/DIRECTION/RESP_VALID drop to 0 the same cycle, no response; on release an auto-LOAD occurs. With IOD_DLY_STAT_EN: STAT_MOVES after the earlier tests equals the sum of pulses, and STAT_CLR zeroes it.

Source files
------------

// File: rtl/iod_dly_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iod_dly_pkg
//  Purpose  : Shared types and helpers for the PF_IOD delay-line step sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package iod_dly_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SETUP = 3'd3,
        ST_MOVE  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } dly_state_t;

    localparam logic DIR_INC = 1'b1;

    // Settle counter must hold SETTLE_CYC itself (LOAD uses the full value).
    function automatic int settle_cnt_w(input int settle_cyc);
        int w;
        w = $clog2(settle_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iod_dly_step_ctrl_settle_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : iod_dly_settle_cnt
//  Purpose  : Loadable saturating down-counter with zero flag for settle waits.
//  Revision : 1.0  initial release
// ============================================================================
module iod_dly_settle_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_zero  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/iod_dly_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iod_dly_step_ctrl
//  Purpose  : Turns absolute tap requests into timed PF_IOD MOVE/LOAD pulses.
//             Optional statistics counters enabled by macro IOD_DLY_STAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module iod_dly_step_ctrl
    import iod_dly_pkg::*;
#(
    parameter int TAP_W      = 8,
    parameter int TAP_MAX    = 255,
    parameter int LOAD_VAL   = 1,
    parameter int SETTLE_CYC = 4
) (
    input  logic             FAB_CLK,
    input  logic             ARST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_LOAD,
    input  logic [TAP_W-1:0] REQ_TARGET,
    output logic             RESP_VALID,
    output logic             RESP_ERR,
    output logic             RESP_CLAMPED,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
`ifdef IOD_DLY_STAT_EN
    ,
    input  logic             STAT_CLR,
    output logic [15:0]      STAT_MOVES,
    output logic [7:0]       STAT_OOR
`endif
);

    localparam int CNT_W = settle_cnt_w(SETTLE_CYC);

    dly_state_t       state_q, state_d;
    logic [TAP_W-1:0] tgt_q, tgt_d;
    logic [TAP_W-1:0] cur_q, cur_d;
    logic             clamp_q, clamp_d;
    logic             dir_q, dir_d;
    logic             auto_q, auto_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_clamp_q, resp_clamp_d;

    logic             w_move, w_load, w_ready;
    logic             w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_val, w_cnt;
    logic [TAP_W-1:0] w_req_tgt;
    logic             w_req_clamp;

    assign w_req_clamp = (REQ_TARGET > TAP_W'(TAP_MAX));
    assign w_req_tgt   = w_req_clamp ? TAP_W'(TAP_MAX) : REQ_TARGET;
    assign w_cnt_dec   = (state_q == ST_LOAD) || (state_q == ST_GAP);

    iod_dly_settle_cnt #(
        .W (CNT_W)
    ) u_settle (
        .clk        (FAB_CLK),
        .rst        (ARST),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cur_d      = cur_q;
        clamp_d    = clamp_q;
        dir_d      = dir_q;
        auto_d     = auto_q;
        w_move     = 1'b0;
        w_load     = 1'b0;
        w_ready    = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_val  = CNT_W'(SETTLE_CYC);

        case (state_q)
            ST_INIT: begin
                auto_d     = 1'b1;
                w_cnt_load = 1'b1;
                state_d    = ST_LOAD;
            end
            ST_IDLE: begin
                w_ready = 1'b1;
                if (REQ_VALID) begin
                    if (REQ_LOAD) begin
                        clamp_d    = 1'b0;
                        w_cnt_load = 1'b1;
                        state_d    = ST_LOAD;
                    end else begin
                        tgt_d   = w_req_tgt;
                        clamp_d = w_req_clamp;
                        // Direction is set on accept so it is stable through SETUP.
                        dir_d   = (w_req_tgt > cur_q);
                        state_d = (w_req_tgt == cur_q) ? ST_DONE : ST_SETUP;
                    end
                end
            end
            ST_LOAD: begin
                // Counter is freshly loaded with SETTLE_CYC only on the first LOAD cycle.
                if (w_cnt == CNT_W'(SETTLE_CYC)) begin
                    w_load = 1'b1;
                    cur_d  = TAP_W'(LOAD_VAL);
                end
                if (w_cnt_zero) begin
                    auto_d  = 1'b0;
                    state_d = auto_q ? ST_IDLE : ST_DONE;
                end
            end
            ST_SETUP: begin
                state_d = ST_MOVE;
            end
            ST_MOVE: begin
                w_move     = 1'b1;
                cur_d      = (dir_q == DIR_INC) ? cur_q + TAP_W'(1) : cur_q - TAP_W'(1);
                w_cnt_load = 1'b1;
                w_cnt_val  = CNT_W'(SETTLE_CYC - 1);
                state_d    = ST_GAP;
            end
            ST_GAP: begin
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    state_d = ST_ERR;
                end else if (w_cnt_zero) begin
                    state_d = (cur_q == tgt_q) ? ST_DONE : ST_MOVE;
                end
            end
            ST_DONE, ST_ERR: begin
                dir_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        resp_valid_d = (state_q == ST_DONE) || (state_q == ST_ERR);
        resp_err_d   = (state_q == ST_ERR);
        resp_clamp_d = (state_q == ST_DONE) && clamp_q;
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q      <= ST_INIT;
            tgt_q        <= '0;
            cur_q        <= TAP_W'(LOAD_VAL);
            clamp_q      <= 1'b0;
            dir_q        <= 1'b0;
            auto_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_clamp_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            cur_q        <= cur_d;
            clamp_q      <= clamp_d;
            dir_q        <= dir_d;
            auto_q       <= auto_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_clamp_q <= resp_clamp_d;
        end
    end

    assign REQ_READY            = w_ready;
    assign RESP_VALID           = resp_valid_q;
    assign RESP_ERR             = resp_err_q;
    assign RESP_CLAMPED         = resp_clamp_q;
    assign CUR_TAP              = cur_q;
    assign DELAY_LINE_MOVE      = w_move;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = w_load;

`ifdef IOD_DLY_STAT_EN
    logic [15:0] stat_moves_q, stat_moves_d;
    logic [7:0]  stat_oor_q, stat_oor_d;

    always_comb begin
        stat_moves_d = stat_moves_q;
        stat_oor_d   = stat_oor_q;
        if (STAT_CLR) begin
            stat_moves_d = '0;
            stat_oor_d   = '0;
        end else begin
            if (w_move && (stat_moves_q != 16'hFFFF)) stat_moves_d = stat_moves_q + 16'd1;
            if ((state_q == ST_ERR) && (stat_oor_q != 8'hFF)) stat_oor_d = stat_oor_q + 8'd1;
        end
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            stat_moves_q <= '0;
            stat_oor_q   <= '0;
        end else begin
            stat_moves_q <= stat_moves_d;
            stat_oor_q   <= stat_oor_d;
        end
    end

    assign STAT_MOVES = stat_moves_q;
    assign STAT_OOR   = stat_oor_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iod_dly_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iod_dly_step_ctrl
//  Purpose  : Directed self-checking bench for iod_dly_step_ctrl
//             (TAP_MAX=200, SETTLE_CYC=4, LOAD_VAL=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_iod_dly_step_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       ARST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic       REQ_LOAD = 1'b0;
    logic [7:0] REQ_TARGET = 8'd0;
    logic       RESP_VALID, RESP_ERR, RESP_CLAMPED;
    logic [7:0] CUR_TAP;
    logic       DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
`ifdef IOD_DLY_STAT_EN
    logic        STAT_CLR = 1'b0;
    logic [15:0] STAT_MOVES;
    logic [7:0]  STAT_OOR;
`endif

    int total = 0;
    int bad = 0;
    logic both_seen = 1'b0;

    int   r_lat, r_moves, r_loads, r_first, r_gmin, r_gmax, r_extra;
    logic r_err, r_clamp, r_dir_bad, r_dir_setup;

    always #5 FAB_CLK = ~FAB_CLK;

    always @(negedge FAB_CLK) if (DELAY_LINE_MOVE && DELAY_LINE_LOAD) both_seen = 1'b1;

    iod_dly_step_ctrl #(
        .TAP_W      (8),
        .TAP_MAX    (200),
        .LOAD_VAL   (1),
        .SETTLE_CYC (4)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST                    (ARST),
        .REQ_VALID               (REQ_VALID),
        .REQ_READY               (REQ_READY),
        .REQ_LOAD                (REQ_LOAD),
        .REQ_TARGET              (REQ_TARGET),
        .RESP_VALID              (RESP_VALID),
        .RESP_ERR                (RESP_ERR),
        .RESP_CLAMPED            (RESP_CLAMPED),
        .CUR_TAP                 (CUR_TAP),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
`ifdef IOD_DLY_STAT_EN
        ,
        .STAT_CLR                (STAT_CLR),
        .STAT_MOVES              (STAT_MOVES),
        .STAT_OOR                (STAT_OOR)
`endif
    );

    // Releases ARST at a falling edge and checks the automatic LOAD boot sequence.
    task automatic check_boot(input string tag);
        ARST = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge FAB_CLK);
            total++;
            if (DELAY_LINE_LOAD !== (k == 1)) begin
                bad++;
                $display("FAIL %s_load_k%0d got=%b exp=%b", tag, k, DELAY_LINE_LOAD, (k == 1));
            end
            total++;
            if (REQ_READY !== (k == 6)) begin
                bad++;
                $display("FAIL %s_ready_k%0d got=%b exp=%b", tag, k, REQ_READY, (k == 6));
            end
            total++;
            if (RESP_VALID !== 1'b0) begin
                bad++;
                $display("FAIL %s_resp_k%0d got=%b exp=0", tag, k, RESP_VALID);
            end
        end
        total++;
        if (CUR_TAP !== 8'd1) begin
            bad++;
            $display("FAIL %s_cur_tap got=%0d exp=1", tag, CUR_TAP);
        end
    endtask

    // Issues one request and records pulses/response until RESP_VALID (bounded).
    task automatic do_req(input logic ld, input logic [7:0] tgt, input int oor_after,
                          input logic exp_dir);
        int w, k, last;
        logic done;
        w = 0;
        while (REQ_READY !== 1'b1 && w < 50) begin
            @(negedge FAB_CLK);
            w++;
        end
        total++;
        if (w >= 50) begin
            bad++;
            $display("FAIL ready_timeout got=%b exp=1", REQ_READY);
        end
        REQ_VALID = 1'b1;
        REQ_LOAD = ld;
        REQ_TARGET = tgt;
        @(posedge FAB_CLK);
        @(negedge FAB_CLK);
        REQ_VALID = 1'b0;
        REQ_LOAD = ~ld;
        REQ_TARGET = ~tgt;
        r_lat = -1; r_moves = 0; r_loads = 0; r_first = -1; r_gmin = 9999; r_gmax = 0;
        r_err = 1'b0; r_clamp = 1'b0; r_dir_bad = 1'b0; r_dir_setup = 1'bx; r_extra = 0;
        k = 1; last = -1; done = 1'b0;
        while (!done && k <= 2000) begin
            if (k == 1) r_dir_setup = DELAY_LINE_DIRECTION;
            if (DELAY_LINE_MOVE === 1'b1) begin
                r_moves++;
                if (last >= 0) begin
                    if (k - last < r_gmin) r_gmin = k - last;
                    if (k - last > r_gmax) r_gmax = k - last;
                end
                if (r_first < 0) r_first = k;
                last = k;
                if (DELAY_LINE_DIRECTION !== exp_dir) r_dir_bad = 1'b1;
                if (r_moves == oor_after) DELAY_LINE_OUT_OF_RANGE = 1'b1;
            end
            if (DELAY_LINE_LOAD === 1'b1) r_loads++;
            if (RESP_VALID === 1'b1) begin
                done = 1'b1;
                r_lat = k;
                r_err = RESP_ERR;
                r_clamp = RESP_CLAMPED;
            end else begin
                @(negedge FAB_CLK);
                k++;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL resp_timeout got=none exp=RESP_VALID within 2000 cycles");
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE === 1'b1) r_extra++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge FAB_CLK);
        total++;
        if ({DELAY_LINE_MOVE, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, RESP_VALID, REQ_READY} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {DELAY_LINE_MOVE, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, RESP_VALID, REQ_READY});
        end
        total++;
        if (CUR_TAP !== 8'd1) begin
            bad++;
            $display("FAIL reset_cur_tap got=%0d exp=1", CUR_TAP);
        end
        check_boot("boot");
    endtask

    task automatic test_move_up();
        do_req(1'b0, 8'd4, 0, 1'b1);
        total++; if (r_moves !== 3) begin bad++; $display("FAIL up_moves got=%0d exp=3", r_moves); end
        total++; if (r_first !== 2) begin bad++; $display("FAIL up_first_move got=%0d exp=2", r_first); end
        total++; if (r_gmin !== 5 || r_gmax !== 5) begin bad++; $display("FAIL up_spacing got=%0d..%0d exp=5", r_gmin, r_gmax); end
        total++; if (r_lat !== 18) begin bad++; $display("FAIL up_latency got=%0d exp=18", r_lat); end
        total++; if (r_dir_setup !== 1'b1 || r_dir_bad) begin bad++; $display("FAIL up_direction got=%b/%b exp=1/0", r_dir_setup, r_dir_bad); end
        total++; if (r_err !== 1'b0 || r_clamp !== 1'b0) begin bad++; $display("FAIL up_flags got=%b%b exp=00", r_err, r_clamp); end
        total++; if (CUR_TAP !== 8'd4) begin bad++; $display("FAIL up_cur_tap got=%0d exp=4", CUR_TAP); end
    endtask

    task automatic test_zero_move();
        do_req(1'b0, 8'd4, 0, 1'b0);
        total++; if (r_moves !== 0) begin bad++; $display("FAIL zero_moves got=%0d exp=0", r_moves); end
        total++; if (r_lat !== 2) begin bad++; $display("FAIL zero_latency got=%0d exp=2", r_lat); end
        total++; if (r_err !== 1'b0) begin bad++; $display("FAIL zero_err got=%b exp=0", r_err); end
        total++; if (CUR_TAP !== 8'd4) begin bad++; $display("FAIL zero_cur_tap got=%0d exp=4", CUR_TAP); end
    endtask

    task automatic test_load_req();
        do_req(1'b1, 8'd77, 0, 1'b0);
        total++; if (r_loads !== 1) begin bad++; $display("FAIL load_pulses got=%0d exp=1", r_loads); end
        total++; if (r_moves !== 0) begin bad++; $display("FAIL load_moves got=%0d exp=0", r_moves); end
        total++; if (r_lat !== 7) begin bad++; $display("FAIL load_latency got=%0d exp=7", r_lat); end
        total++; if (CUR_TAP !== 8'd1) begin bad++; $display("FAIL load_cur_tap got=%0d exp=1", CUR_TAP); end
    endtask

    task automatic test_long_move();
        do_req(1'b0, 8'd198, 0, 1'b1);
        total++; if (r_moves !== 197) begin bad++; $display("FAIL long_moves got=%0d exp=197", r_moves); end
        total++; if (r_lat !== 988) begin bad++; $display("FAIL long_latency got=%0d exp=988", r_lat); end
        total++; if (CUR_TAP !== 8'd198) begin bad++; $display("FAIL long_cur_tap got=%0d exp=198", CUR_TAP); end
    endtask

    task automatic test_clamp();
        do_req(1'b0, 8'd250, 0, 1'b1);
        total++; if (r_moves !== 2) begin bad++; $display("FAIL clamp_moves got=%0d exp=2", r_moves); end
        total++; if (r_lat !== 13) begin bad++; $display("FAIL clamp_latency got=%0d exp=13", r_lat); end
        total++; if (r_clamp !== 1'b1) begin bad++; $display("FAIL clamp_flag got=%b exp=1", r_clamp); end
        total++; if (CUR_TAP !== 8'd200) begin bad++; $display("FAIL clamp_cur_tap got=%0d exp=200", CUR_TAP); end
    endtask

    task automatic test_out_of_range();
        do_req(1'b0, 8'd195, 2, 1'b0);
        total++; if (r_moves !== 2 || r_extra !== 0) begin bad++; $display("FAIL oor_moves got=%0d+%0d exp=2+0", r_moves, r_extra); end
        total++; if (r_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", r_err); end
        total++; if (r_lat !== 10) begin bad++; $display("FAIL oor_latency got=%0d exp=10", r_lat); end
        total++; if (r_dir_bad) begin bad++; $display("FAIL oor_direction got=bad exp=0 at each MOVE"); end
        total++; if (CUR_TAP !== 8'd198) begin bad++; $display("FAIL oor_cur_tap got=%0d exp=198", CUR_TAP); end
    endtask

    task automatic test_exclusive();
        total++;
        if (both_seen !== 1'b0) begin
            bad++;
            $display("FAIL move_load_overlap got=%b exp=0", both_seen);
        end
    endtask

`ifdef IOD_DLY_STAT_EN
    task automatic test_stats();
        total++; if (STAT_MOVES !== 16'd204) begin bad++; $display("FAIL stat_moves got=%0d exp=204", STAT_MOVES); end
        total++; if (STAT_OOR !== 8'd1) begin bad++; $display("FAIL stat_oor got=%0d exp=1", STAT_OOR); end
        STAT_CLR = 1'b1;
        @(negedge FAB_CLK);
        STAT_CLR = 1'b0;
        total++; if (STAT_MOVES !== 16'd0 || STAT_OOR !== 8'd0) begin bad++; $display("FAIL stat_clear got=%0d/%0d exp=0/0", STAT_MOVES, STAT_OOR); end
    endtask
`endif

    task automatic test_reset_mid();
        int w;
        w = 0;
        while (REQ_READY !== 1'b1 && w < 50) begin
            @(negedge FAB_CLK);
            w++;
        end
        REQ_VALID = 1'b1;
        REQ_LOAD = 1'b0;
        REQ_TARGET = 8'd220;
        @(posedge FAB_CLK);
        @(negedge FAB_CLK);
        REQ_VALID = 1'b0;
        @(negedge FAB_CLK);
        total++; if (DELAY_LINE_MOVE !== 1'b1) begin bad++; $display("FAIL mid_first_move got=%b exp=1", DELAY_LINE_MOVE); end
        @(negedge FAB_CLK);
        total++; if (DELAY_LINE_DIRECTION !== 1'b1) begin bad++; $display("FAIL mid_gap_dir got=%b exp=1", DELAY_LINE_DIRECTION); end
        ARST = 1'b1;
        #1;
        total++;
        if ({DELAY_LINE_MOVE, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, RESP_VALID} !== 4'b0) begin
            bad++;
            $display("FAIL mid_reset_drop got=%b exp=0000",
                     {DELAY_LINE_MOVE, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, RESP_VALID});
        end
        total++; if (CUR_TAP !== 8'd1) begin bad++; $display("FAIL mid_reset_cur_tap got=%0d exp=1", CUR_TAP); end
        repeat (2) @(negedge FAB_CLK);
        check_boot("reboot");
    endtask

    initial begin
        test_reset();
        test_move_up();
        test_zero_move();
        test_load_req();
        test_long_move();
        test_clamp();
        test_out_of_range();
        test_exclusive();
`ifdef IOD_DLY_STAT_EN
        test_stats();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
